// File: rtl/lc3_isdu_control.sv
// LC-3 instruction sequencing/decode unit: Moore FSM driving datapath loads, gates,
// mux selects, ALU op and SRAM strobes, with MEM_WAIT-cycle memory accesses.
module lc3_isdu_control #(
  parameter int MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       DRMUX,
  output logic [1:0] ALUK,
  output logic       MIO_EN,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  // state  | meaning
  // HALTED | idle after reset, waits for Run
  // S18    | MAR <- PC, PC <- PC+1
  // S33    | instruction read, MDR loads on last wait cycle
  // S35    | IR <- MDR
  // S32    | BEN latch, opcode dispatch
  // S1/S5/S9 | ADD / AND / NOT into DR
  // S0/S22 | BR test / BR taken
  // S12    | JMP
  // S4/S21 | JSR: R7 <- PC, then PC <- PC + off11
  // S6/S25/S27 | LDR: address, read, DR <- MDR
  // S7/S23/S16 | STR: address, MDR <- SR, write
  // P1/P2  | PAUSE: wait for Continue press, then release
  typedef enum logic [4:0] {
    HALTED, S18, S33, S35, S32, S1, S5, S9, S0, S22, S12,
    S4, S21, S6, S7, S25, S27, S23, S16, P1, P2
  } state_t;

  localparam int WCW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [WCW-1:0] WCNT_LAST = WCW'(MEM_WAIT - 1);

  state_t         state;
  logic [WCW-1:0] wcnt;
  logic           last;

  assign last = (wcnt == WCNT_LAST);

  // wcnt is zero on every memory-state entry because each exit clears it
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= HALTED;
      wcnt  <= '0;
    end else begin
      case (state)
        HALTED: if (Run) state <= S18;
        S18:    state <= S33;
        S33: begin
          if (last) begin
            state <= S35;
            wcnt  <= '0;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S35:    state <= S32;
        S32: begin
          case (Opcode)
            4'b0001: state <= S1;
            4'b0101: state <= S5;
            4'b1001: state <= S9;
            4'b0000: state <= S0;
            4'b1100: state <= S12;
            4'b0100: state <= S4;
            4'b0110: state <= S6;
            4'b0111: state <= S7;
            4'b1101: state <= P1;
            default: state <= S18;
          endcase
        end
        S1, S5, S9, S22, S12, S21, S27: state <= S18;
        S0:     state <= BEN ? S22 : S18;
        S4:     state <= S21;
        S6:     state <= S25;
        S7:     state <= S23;
        S25: begin
          if (last) begin
            state <= S27;
            wcnt  <= '0;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S23:    state <= S16;
        S16: begin
          if (last) begin
            state <= S18;
            wcnt  <= '0;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        P1:     if (Continue) state <= P2;
        P2:     if (!Continue) state <= S18;
        default: state <= HALTED;
      endcase
    end
  end

  always_comb begin
    LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
    LD_CC = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0; LD_LED = 1'b0;
    GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
    PCMUX = 2'b00; ADDR1MUX = 1'b0; ADDR2MUX = 2'b00;
    SR1MUX = 1'b0; SR2MUX = 1'b0; DRMUX = 1'b0; ALUK = 2'b00;
    MIO_EN = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b0;
    case (state)
      S18: begin
        GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1;
      end
      S33, S25: begin
        Mem_OE = 1'b1;
        LD_MDR = last;
      end
      S35: begin
        GateMDR = 1'b1; LD_IR = 1'b1;
      end
      S32: LD_BEN = 1'b1;
      S1, S5, S9: begin
        SR2MUX  = ~IR_5;
        ALUK    = (state == S1) ? 2'b00 : (state == S5) ? 2'b01 : 2'b10;
        GateALU = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
      end
      S22: begin
        ADDR1MUX = 1'b1; ADDR2MUX = 2'b10; PCMUX = 2'b10; LD_PC = 1'b1;
      end
      S12: begin
        PCMUX = 2'b10; LD_PC = 1'b1;
      end
      S4: begin
        GatePC = 1'b1; LD_REG = 1'b1;
      end
      S21: begin
        ADDR1MUX = 1'b1; ADDR2MUX = 2'b11; PCMUX = 2'b10; LD_PC = 1'b1;
      end
      S6, S7: begin
        ADDR2MUX = 2'b01; GateMARMUX = 1'b1; LD_MAR = 1'b1;
      end
      S27: begin
        GateMDR = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
      end
      S23: begin
        SR1MUX = 1'b1; ALUK = 2'b11; GateALU = 1'b1; MIO_EN = 1'b1; LD_MDR = 1'b1;
      end
      S16: Mem_WE = 1'b1;
      P1:  LD_LED = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lc3_isdu_control.sv
// Bench for lc3_isdu_control: per-instruction expected control-word sequences are
// queued from the instruction semantics and compared cycle by cycle.
module tb_lc3_isdu_control;
  localparam int M = 3;

  logic Clk = 1'b0;
  logic Reset, Run, Continue, IR_5, BEN;
  logic [3:0] Opcode;
  logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic ADDR1MUX, SR1MUX, SR2MUX, DRMUX, MIO_EN, Mem_OE, Mem_WE;

  lc3_isdu_control #(.MEM_WAIT(M)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .BEN(BEN), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR),
    .LD_BEN(LD_BEN), .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .SR1MUX(SR1MUX),
    .SR2MUX(SR2MUX), .DRMUX(DRMUX), .ALUK(ALUK), .MIO_EN(MIO_EN),
    .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
  );

  always #5 Clk = ~Clk;

  logic [24:0] obs;
  assign obs = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, ADDR1MUX, ADDR2MUX,
                SR1MUX, SR2MUX, DRMUX, ALUK, MIO_EN, Mem_OE, Mem_WE};

  localparam logic [24:0] C_LD_MAR = 25'd1 << 24, C_LD_MDR = 25'd1 << 23,
    C_LD_IR = 25'd1 << 22, C_LD_BEN = 25'd1 << 21, C_LD_CC = 25'd1 << 20,
    C_LD_REG = 25'd1 << 19, C_LD_PC = 25'd1 << 18, C_LD_LED = 25'd1 << 17,
    C_GPC = 25'd1 << 16, C_GMDR = 25'd1 << 15, C_GALU = 25'd1 << 14,
    C_GMAR = 25'd1 << 13, C_A1 = 25'd1 << 10, C_SR1 = 25'd1 << 7,
    C_SR2 = 25'd1 << 6, C_DR = 25'd1 << 5, C_MIO = 25'd1 << 2,
    C_OE = 25'd1 << 1, C_WE = 25'd1;

  function automatic logic [24:0] pcmux(input int x);  return 25'(x) << 11; endfunction
  function automatic logic [24:0] addr2(input int x);  return 25'(x) << 8;  endfunction
  function automatic logic [24:0] aluk(input int x);   return 25'(x) << 3;  endfunction

  typedef struct packed {
    logic [24:0] v;
    logic [3:0]  op;
    logic        ir5;
    logic        ben;
    logic        cont;
  } ent_t;

  ent_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic push(input logic [24:0] v, input logic [3:0] op, input logic ir5,
                      input logic ben, input logic cont);
    ent_t e;
    e.v = v; e.op = op; e.ir5 = ir5; e.ben = ben; e.cont = cont;
    q.push_back(e);
  endtask

  // Memory access of M cycles; a read loads MDR only on its final cycle
  task automatic push_mem(input logic rd, input logic [3:0] op, input logic ir5, input logic ben);
    for (int i = 0; i < M; i++)
      push(rd ? (C_OE | ((i == M - 1) ? C_LD_MDR : 25'd0)) : C_WE, op, ir5, ben, 1'b0);
  endtask

  task automatic gen_instr(input logic [3:0] op, input logic ir5, input logic ben,
                           input int k, input int j);
    push(C_GPC | C_LD_MAR | C_LD_PC, op, ir5, ben, 1'b0);
    push_mem(1'b1, op, ir5, ben);
    push(C_GMDR | C_LD_IR, op, ir5, ben, 1'b0);
    push(C_LD_BEN, op, ir5, ben, 1'b0);
    case (op)
      4'b0001, 4'b0101, 4'b1001:
        push((ir5 ? 25'd0 : C_SR2) | aluk(op == 4'b0001 ? 0 : op == 4'b0101 ? 1 : 2) |
             C_GALU | C_DR | C_LD_REG | C_LD_CC, op, ir5, ben, 1'b0);
      4'b0000: begin
        push(25'd0, op, ir5, ben, 1'b0);
        if (ben) push(C_A1 | addr2(2) | pcmux(2) | C_LD_PC, op, ir5, ben, 1'b0);
      end
      4'b1100: push(pcmux(2) | C_LD_PC, op, ir5, ben, 1'b0);
      4'b0100: begin
        push(C_GPC | C_LD_REG, op, ir5, ben, 1'b0);
        push(C_A1 | addr2(3) | pcmux(2) | C_LD_PC, op, ir5, ben, 1'b0);
      end
      4'b0110: begin
        push(addr2(1) | C_GMAR | C_LD_MAR, op, ir5, ben, 1'b0);
        push_mem(1'b1, op, ir5, ben);
        push(C_GMDR | C_DR | C_LD_REG | C_LD_CC, op, ir5, ben, 1'b0);
      end
      4'b0111: begin
        push(addr2(1) | C_GMAR | C_LD_MAR, op, ir5, ben, 1'b0);
        push(C_SR1 | aluk(3) | C_GALU | C_MIO | C_LD_MDR, op, ir5, ben, 1'b0);
        push_mem(1'b0, op, ir5, ben);
      end
      4'b1101: begin
        // Continue pressed on the k-th P1 cycle, released on the j-th P2 cycle
        for (int i = 0; i < k; i++) push(C_LD_LED, op, ir5, ben, i == k - 1);
        for (int i = 0; i < j; i++) push(25'd0, op, ir5, ben, i != j - 1);
      end
      default: ;
    endcase
  endtask

  task automatic check(input string tag, input logic [24:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_n(input int n, input bit rand_run);
    ent_t e;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      @(negedge Clk);
      e = q.pop_front();
      Opcode = e.op; IR_5 = e.ir5; BEN = e.ben; Continue = e.cont;
      if (rand_run) Run = 1'($urandom_range(1));
      cyc++;
      #1 check($sformatf("cyc%0d_op%0h", cyc, e.op), e.v);
    end
  endtask

  initial begin
    Reset = 1'b0; Run = 1'b0; Continue = 1'b0; Opcode = 4'h0; IR_5 = 1'b0; BEN = 1'b0;
    repeat (3) begin @(negedge Clk); #1 check("reset_hold", 25'd0); end
    Run = 1'b1;
    @(negedge Clk); #1 check("reset_run_ignored", 25'd0);
    @(negedge Clk); Reset = 1'b1; Run = 1'b0;
    repeat (10) begin @(negedge Clk); #1 check("halted_idle", 25'd0); end
    Run = 1'b1;

    gen_instr(4'b0001, 1'b1, 1'b0, 1, 1);   // ADD immediate
    gen_instr(4'b0101, 1'b0, 1'b0, 1, 1);   // AND register
    gen_instr(4'b1001, 1'b1, 1'b1, 1, 1);   // NOT
    gen_instr(4'b0000, 1'b0, 1'b0, 1, 1);   // BR not taken
    gen_instr(4'b0000, 1'b1, 1'b1, 1, 1);   // BR taken
    gen_instr(4'b1100, 1'b0, 1'b0, 1, 1);   // JMP
    gen_instr(4'b0100, 1'b0, 1'b0, 1, 1);   // JSR
    gen_instr(4'b0110, 1'b0, 1'b0, 1, 1);   // LDR
    gen_instr(4'b0111, 1'b1, 1'b0, 1, 1);   // STR
    gen_instr(4'b1101, 1'b0, 1'b0, 11, 3);  // PAUSE, Continue low for 10 cycles
    gen_instr(4'b0011, 1'b0, 1'b0, 1, 1);   // undefined opcode
    run_n(q.size(), 1'b0);

    for (int n = 0; n < 60; n++)
      gen_instr(4'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                $urandom_range(1, 4), $urandom_range(1, 4));
    run_n(q.size(), 1'b1);

    // Reset asserted during the first write cycle of a store
    gen_instr(4'b0111, 1'b0, 1'b0, 1, 1);
    run_n(q.size() - (M - 1), 1'b0);
    #2 Reset = 1'b0;
    #1 check("reset_mid_s16", 25'd0);
    q.delete();
    Run = 1'b1;
    repeat (3) begin @(negedge Clk); #1 check("reset_after_s16", 25'd0); end
    Reset = 1'b1; Run = 1'b0;
    repeat (3) begin @(negedge Clk); #1 check("halted_after_s16", 25'd0); end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
